// File: rtl/mem_stage_if.sv
// rtl/mem_stage_if.sv - data-memory port between mem_stage and the data memory
interface mem_stage_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  mem_req;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [3:0]            mem_be;
    logic [31:0]           mem_wdata;
    logic                  mem_ack;
    logic [31:0]           mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - memory-access pipeline stage; optional misaligned trap via MEM_MISALIGN_TRAP_EN
module mem_stage #(
    parameter int ADDR_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      in_valid,
    input  logic                      write,
    input  logic [REG_ADDR_WIDTH-1:0] write_address,
    input  logic [31:0]               write_data,
    input  logic [3:0]                memop,
    input  logic [31:0]               store_data,
    output logic                      stall_req,
    mem_stage_if.master               mem,
    output logic                      valid_o,
    output logic                      write_o,
    output logic [REG_ADDR_WIDTH-1:0] write_address_o,
    output logic [31:0]               write_data_o,
    output logic                      exc_o
);
    localparam logic [3:0] OP_LB  = 4'd1;
    localparam logic [3:0] OP_LH  = 4'd2;
    localparam logic [3:0] OP_LW  = 4'd3;
    localparam logic [3:0] OP_LBU = 4'd4;
    localparam logic [3:0] OP_LHU = 4'd5;
    localparam logic [3:0] OP_SB  = 4'd6;
    localparam logic [3:0] OP_SH  = 4'd7;
    localparam logic [3:0] OP_SW  = 4'd8;

    typedef enum logic {S_IDLE, S_BUSY} state_t;

    state_t r_state, w_next;

    logic                      r_mem_req, r_mem_we;
    logic [ADDR_WIDTH-1:0]     r_mem_addr;
    logic [3:0]                r_mem_be;
    logic [31:0]               r_mem_wdata;
    logic [3:0]                r_op;
    logic [1:0]                r_off;
    logic                      r_wr;
    logic [REG_ADDR_WIDTH-1:0] r_wa;
    logic [31:0]               r_alu;
    logic                      r_valid, r_write, r_exc;
    logic [REG_ADDR_WIDTH-1:0] r_wa_o;
    logic [31:0]               r_wd_o;

    logic        w_is_load, w_is_store, w_is_mem;
    logic        w_is_byte, w_is_half;
    logic [1:0]  w_off;
    logic        w_trap, w_issue;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic        w_r_is_load;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load_data;

    assign w_is_load  = (memop >= OP_LB) && (memop <= OP_LHU);
    assign w_is_store = (memop >= OP_SB) && (memop <= OP_SW);
    assign w_is_mem   = w_is_load || w_is_store;
    assign w_is_byte  = (memop == OP_LB) || (memop == OP_LBU) || (memop == OP_SB);
    assign w_is_half  = (memop == OP_LH) || (memop == OP_LHU) || (memop == OP_SH);

`ifdef MEM_MISALIGN_TRAP_EN
    logic w_misalign;
    assign w_misalign = (w_is_half && write_data[0]) ||
                        (!w_is_byte && !w_is_half && (write_data[1:0] != 2'b00));
    assign w_trap = in_valid && w_is_mem && w_misalign;
    assign w_off  = write_data[1:0];
`else
    // Without the trap, misaligned low bits are dropped so the access stays in-word.
    assign w_trap = 1'b0;
    assign w_off  = w_is_byte ? write_data[1:0] :
                    w_is_half ? {write_data[1], 1'b0} : 2'b00;
`endif

    assign w_issue = in_valid && w_is_mem && !w_trap;

    assign w_be    = w_is_byte ? (4'b0001 << w_off) :
                     w_is_half ? (w_off[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    assign w_wdata = w_is_byte ? {4{store_data[7:0]}} :
                     w_is_half ? {2{store_data[15:0]}} : store_data;

    assign w_r_is_load = (r_op >= OP_LB) && (r_op <= OP_LHU);
    assign w_byte      = mem.mem_rdata[{r_off, 3'b000} +: 8];
    assign w_half      = r_off[1] ? mem.mem_rdata[31:16] : mem.mem_rdata[15:0];

    // Extract and extend the addressed byte/half of the returned word
    always_comb begin
        w_load_data = mem.mem_rdata;
        case (r_op)
            OP_LB:   w_load_data = {{24{w_byte[7]}}, w_byte};
            OP_LH:   w_load_data = {{16{w_half[15]}}, w_half};
            OP_LBU:  w_load_data = {24'd0, w_byte};
            OP_LHU:  w_load_data = {16'd0, w_half};
            default: w_load_data = mem.mem_rdata;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // Next-state: enter BUSY on an issued access, leave on ack
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_issue) w_next = S_BUSY;
            S_BUSY:  if (mem.mem_ack) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Output decode: hold upstream while an access is pending
    always_comb begin
        stall_req = 1'b0;
        case (r_state)
            S_IDLE:  stall_req = w_issue;
            S_BUSY:  stall_req = !mem.mem_ack;
            default: stall_req = 1'b0;
        endcase
    end

    // Datapath: memory request capture and writeback output register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_be    <= 4'd0;
            r_mem_wdata <= 32'd0;
            r_op        <= 4'd0;
            r_off       <= 2'd0;
            r_wr        <= 1'b0;
            r_wa        <= '0;
            r_alu       <= 32'd0;
            r_valid     <= 1'b0;
            r_write     <= 1'b0;
            r_exc       <= 1'b0;
            r_wa_o      <= '0;
            r_wd_o      <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (!in_valid) begin
                        r_valid <= 1'b0;
                        r_write <= 1'b0;
                        r_exc   <= 1'b0;
                    end else if (w_trap) begin
                        r_valid <= 1'b1;
                        r_exc   <= 1'b1;
                        r_write <= 1'b0;
                        r_wa_o  <= write_address;
                        r_wd_o  <= write_data;
                    end else if (w_is_mem) begin
                        r_mem_req   <= 1'b1;
                        r_mem_we    <= w_is_store;
                        r_mem_addr  <= {write_data[ADDR_WIDTH-1:2], 2'b00};
                        r_mem_be    <= w_be;
                        r_mem_wdata <= w_wdata;
                        r_op        <= memop;
                        r_off       <= w_off;
                        r_wr        <= write;
                        r_wa        <= write_address;
                        r_alu       <= write_data;
                        r_valid     <= 1'b0;
                        r_write     <= 1'b0;
                        r_exc       <= 1'b0;
                    end else begin
                        r_valid <= 1'b1;
                        r_write <= write;
                        r_wa_o  <= write_address;
                        r_wd_o  <= write_data;
                        r_exc   <= 1'b0;
                    end
                end
                S_BUSY: begin
                    if (mem.mem_ack) begin
                        r_mem_req <= 1'b0;
                        r_valid   <= 1'b1;
                        r_write   <= r_wr;
                        r_wa_o    <= r_wa;
                        r_wd_o    <= w_r_is_load ? w_load_data : r_alu;
                        r_exc     <= 1'b0;
                    end
                end
                default: r_mem_req <= 1'b0;
            endcase
        end
    end

    assign mem.mem_req   = r_mem_req;
    assign mem.mem_we    = r_mem_we;
    assign mem.mem_addr  = r_mem_addr;
    assign mem.mem_be    = r_mem_be;
    assign mem.mem_wdata = r_mem_wdata;

    assign valid_o         = r_valid;
    assign write_o         = r_write;
    assign write_address_o = r_wa_o;
    assign write_data_o    = r_wd_o;
    assign exc_o           = r_exc;
endmodule
